riscv_lsu: RTL and testbench

- Load/store unit in the MEM stage. Issues loads and stores from EX to the data-memory bus.
- Aligns store data and byte strobes. Extracts and sign/zero-extends load data.
- Presents a registered result to writeback as data_o, data_addr_o, mem2reg_o and data_we_o. Writeback picks data_o when mem2reg_o=1.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/riscv_lsu.sv | 173 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: bus request is combinational from EX in IDLE; WB outputs register one edge after retire.
// Loads retire on the edge after rvalid. EX is stalled from issue until store grant or load rvalid.
module riscv_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            ex_valid_i,
    input  logic            ex_mem_re_i,
    input  logic            ex_mem_we_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [AW-1:0]   ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            ex_rd_we_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [AW-1:0]   dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic            mem2reg_o,
    output logic            data_we_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state, state_nxt;
    logic              is_mem, mis, issue;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [AW-1:0]     lat_addr;
    logic [3:0]        lat_be;
    logic [XLEN-1:0]   lat_wdata;
    logic              lat_store;
    logic [2:0]        lat_f3;
    logic              lat_rd_we;
    logic [XLEN-1:0]   rshift, load_ext;

    assign is_mem = ex_mem_re_i | ex_mem_we_i;

    // Size decode doubles as the alignment check; unused funct3 codes never reach the bus.
    always_comb begin
        mis     = 1'b0;
        be_c    = 4'b0000;
        wdata_c = ex_wdata_i;
        case (ex_funct3_i)
            3'b000, 3'b100: begin
                be_c    = 4'b0001 << ex_addr_i[1:0];
                wdata_c = {(XLEN/8){ex_wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                mis     = ex_addr_i[0];
                be_c    = 4'b0011 << ex_addr_i[1:0];
                wdata_c = {(XLEN/16){ex_wdata_i[15:0]}};
            end
            3'b010: begin
                mis  = |ex_addr_i[1:0];
                be_c = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    // Gating with rstn_i keeps the combinational request quiet while reset is held.
    assign issue = rstn_i && (state == IDLE) && ex_valid_i && is_mem && !mis;

    always_comb begin
        state_nxt    = state;
        stall_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = ex_mem_we_i;
                    dmem_be_o    = be_c;
                    dmem_addr_o  = {ex_addr_i[AW-1:2], 2'b00};
                    dmem_wdata_o = wdata_c;
                    stall_o      = !(ex_mem_we_i && dmem_gnt_i);
                    if (dmem_gnt_i)
                        state_nxt = ex_mem_we_i ? IDLE : RESP;
                    else
                        state_nxt = REQ;
                end
            end
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = lat_store;
                dmem_be_o    = lat_be;
                dmem_addr_o  = {lat_addr[AW-1:2], 2'b00};
                dmem_wdata_o = lat_wdata;
                stall_o      = !(lat_store && dmem_gnt_i);
                if (dmem_gnt_i)
                    state_nxt = lat_store ? IDLE : RESP;
            end
            RESP: begin
                stall_o = !dmem_rvalid_i;
                if (dmem_rvalid_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rshift = dmem_rdata_i >> {lat_addr[1:0], 3'b000};

    always_comb begin
        load_ext = dmem_rdata_i;
        case (lat_f3)
            3'b000:  load_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
            3'b001:  load_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_be      <= 4'b0000;
            lat_wdata   <= '0;
            lat_store   <= 1'b0;
            lat_f3      <= 3'b000;
            lat_rd_we   <= 1'b0;
            data_o      <= '0;
            data_addr_o <= '0;
            mem2reg_o   <= 1'b0;
            data_we_o   <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_we_o  <= 1'b0;
            misalign_o <= 1'b0;
            if (issue) begin
                lat_addr  <= ex_addr_i;
                lat_be    <= be_c;
                lat_wdata <= wdata_c;
                lat_store <= ex_mem_we_i;
                lat_f3    <= ex_funct3_i;
                lat_rd_we <= ex_rd_we_i;
            end
            if (state == IDLE && ex_valid_i) begin
                if (!is_mem) begin
                    data_addr_o <= XLEN'(ex_addr_i);
                    mem2reg_o   <= 1'b0;
                    data_we_o   <= ex_rd_we_i;
                end else if (mis) begin
                    misalign_o <= 1'b1;
                end
            end
            if (state == RESP && dmem_rvalid_i) begin
                data_o      <= load_ext;
                mem2reg_o   <= 1'b1;
                data_we_o   <= lat_rd_we;
                data_addr_o <= XLEN'(lat_addr);
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: byte-level memory model predicts bus and writeback events into a queue,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        ex_valid_i = 1'b0, ex_mem_re_i = 1'b0, ex_mem_we_i = 1'b0, ex_rd_we_i = 1'b0;
    logic [2:0]  ex_funct3_i = 3'b000;
    logic [31:0] ex_addr_i = '0, ex_wdata_i = '0;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] data_o, data_addr_o;
    logic        mem2reg_o, data_we_o, misalign_o;

    riscv_lsu #(.XLEN(32), .AW(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .ex_valid_i(ex_valid_i), .ex_mem_re_i(ex_mem_re_i), .ex_mem_we_i(ex_mem_we_i),
        .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_we_i(ex_rd_we_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .data_o(data_o), .data_addr_o(data_addr_o), .mem2reg_o(mem2reg_o),
        .data_we_o(data_we_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int K_WB = 0, K_BUS = 1, K_MIS = 2;
    typedef struct {
        int          kind;
        logic [31:0] d;
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic        m;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] bmem [64];
    int         n_cmp = 0, n_bad = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Reference model: architectural effect of one instruction on bus, memory and writeback.
    function automatic void expect_instr(input logic re, input logic we, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] wd, input logic rdwe);
        ev_t         e;
        int          n, lo;
        logic [31:0] v;
        e.kind = K_WB; e.d = '0; e.a = a; e.be = 4'b0000; e.we = 1'b0; e.m = 1'b0;
        if (!(re || we)) begin
            if (rdwe) expq.push_back(e);
            return;
        end
        case (f3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        lo = int'(a[1:0]);
        if (n == 0 || (lo % n) != 0) begin
            e.kind = K_MIS;
            expq.push_back(e);
            return;
        end
        e.kind = K_BUS;
        e.a    = {a[31:2], 2'b00};
        e.we   = we;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                e.be[lo + i] = 1'b1;
                bmem[a[5:0] + 6'(i)] = wd[8*i +: 8];
            end
            for (int l = 0; l < 4; l++) e.d[8*l +: 8] = wd[8*(l % n) +: 8];
            expq.push_back(e);
        end else begin
            expq.push_back(e);
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[a[5:0] + 6'(i)];
            if (!f3[2] && n < 4 && v[8*n-1])
                for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            if (rdwe) begin
                e.kind = K_WB; e.a = a; e.d = v; e.m = 1'b1; e.we = 1'b0;
                expq.push_back(e);
            end
        end
    endfunction

    task automatic check_ev(input int k);
        ev_t e;
        n_cmp++;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = expq.pop_front();
        if (e.kind != k) begin
            n_bad++;
            $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
            return;
        end
        if (k == K_WB) begin
            chk32("wb_addr", data_addr_o, e.a);
            chk1("wb_mem2reg", mem2reg_o, e.m);
            if (e.m) chk32("wb_data", data_o, e.d);
        end else if (k == K_BUS) begin
            chk32("bus_addr", dmem_addr_o, e.a);
            chk1("bus_we", dmem_we_o, e.we);
            if (e.we) begin
                chk32("bus_be", 32'(dmem_be_o), 32'(e.be));
                chk32("bus_wdata", dmem_wdata_o, e.d);
            end
        end
    endtask

    // Registered events belong to older instructions, so they are checked before the bus.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (data_we_o)                check_ev(K_WB);
            if (misalign_o)               check_ev(K_MIS);
            if (dmem_req_o && dmem_gnt_i) check_ev(K_BUS);
        end
    end

    // Memory responder: programmable grant and read-data delays.
    int         cfg_gnt = 0, cfg_rv = 0, gnt_cnt = -1, rv_cnt = 0;
    logic       rv_pend = 1'b0, stray_rv = 1'b0;
    logic [3:0] rv_word = '0;

    function automatic logic [31:0] word_at(input logic [3:0] w);
        return {bmem[{w, 2'd3}], bmem[{w, 2'd2}], bmem[{w, 2'd1}], bmem[{w, 2'd0}]};
    endfunction

    always begin
        @(posedge clk_i);
        #2;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (!rstn_i) begin
            gnt_cnt = -1;
            rv_pend = 1'b0;
        end else begin
            if (stray_rv) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = 32'hDEAD_BEEF;
                stray_rv      = 1'b0;
            end else if (rv_pend) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = word_at(rv_word);
                    rv_pend       = 1'b0;
                end else rv_cnt--;
            end
            if (dmem_req_o) begin
                if (gnt_cnt < 0) gnt_cnt = cfg_gnt;
                if (gnt_cnt == 0) begin
                    dmem_gnt_i = 1'b1;
                    gnt_cnt    = -1;
                    if (!dmem_we_o) begin
                        rv_pend = 1'b1;
                        rv_cnt  = cfg_rv;
                        rv_word = dmem_addr_o[5:2];
                    end
                end else gnt_cnt--;
            end
        end
    end

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic rdwe);
        ex_valid_i = 1'b1; ex_mem_re_i = re; ex_mem_we_i = we; ex_funct3_i = f3;
        ex_addr_i = a; ex_wdata_i = wd; ex_rd_we_i = rdwe;
    endtask

    task automatic idle_ex();
        ex_valid_i = 1'b0; ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic rdwe);
        int t;
        expect_instr(re, we, f3, a, wd, rdwe);
        drive(re, we, f3, a, wd, rdwe);
        t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (stall_o && t < 100);
        if (stall_o) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: stall_o still 1 after %0d cycles, required 0", t);
        end
        sync();
        idle_ex();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        rdwe, re;
        int          op;
        for (int i = 0; i < 64; i++) bmem[i] = 8'($urandom);

        // Reset state, with a load presented to prove the request stays gated.
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        @(negedge clk_i);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_req", dmem_req_o, 1'b0);
        chk1("rst_we", dmem_we_o, 1'b0);
        chk32("rst_be", 32'(dmem_be_o), 32'h0);
        chk32("rst_addr", dmem_addr_o, 32'h0);
        chk32("rst_wdata", dmem_wdata_o, 32'h0);
        chk32("rst_data", data_o, 32'h0);
        chk32("rst_data_addr", data_addr_o, 32'h0);
        chk1("rst_mem2reg", mem2reg_o, 1'b0);
        chk1("rst_data_we", data_we_o, 1'b0);
        chk1("rst_misalign", misalign_o, 1'b0);
        idle_ex();
        sync();
        rstn_i = 1'b1;
        sync();

        // Non-memory pass-through.
        expect_instr(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1);
        @(negedge clk_i);
        chk1("alu_stall", stall_o, 1'b0);
        sync();
        idle_ex();
        @(negedge clk_i);
        chk1("alu_we_pulse", data_we_o, 1'b1);
        chk32("alu_addr", data_addr_o, 32'h0000_1234);
        @(negedge clk_i);
        chk1("alu_we_drop", data_we_o, 1'b0);
        sync();

        // LB / LBU at 0x103 of word 0x80AA_BBCC.
        bmem[0] = 8'hCC; bmem[1] = 8'hBB; bmem[2] = 8'hAA; bmem[3] = 8'h80;
        cfg_gnt = 0; cfg_rv = 0;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1);
        @(negedge clk_i);
        chk32("lb_data", data_o, 32'hFFFF_FF80);
        chk1("lb_mem2reg", mem2reg_o, 1'b1);
        sync();
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b1);
        @(negedge clk_i);
        chk32("lbu_data", data_o, 32'h0000_0080);
        sync();

        // SH at 0x102 with a three-cycle grant delay.
        cfg_gnt = 3;
        expect_instr(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 1'b1);
        drive(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk1("sh_req", dmem_req_o, 1'b1);
            chk32("sh_addr", dmem_addr_o, 32'h0000_0100);
            chk32("sh_be", 32'(dmem_be_o), 32'h0000_000C);
            chk32("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
            chk1("sh_stall", stall_o, (i < 3));
        end
        sync();
        idle_ex();
        @(negedge clk_i);
        chk1("sh_no_wb", data_we_o, 1'b0);
        sync();
        cfg_gnt = 0;

        // Misaligned LW.
        expect_instr(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b1);
        @(negedge clk_i);
        chk1("mis_no_req", dmem_req_o, 1'b0);
        chk1("mis_no_stall", stall_o, 1'b0);
        sync();
        idle_ex();
        @(negedge clk_i);
        chk1("mis_pulse", misalign_o, 1'b1);
        chk1("mis_no_wb", data_we_o, 1'b0);
        @(negedge clk_i);
        chk1("mis_pulse_end", misalign_o, 1'b0);
        sync();

        // Reset while a load waits for read data.
        cfg_rv = 5;
        expect_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        begin
            ev_t e;
            e.kind = K_BUS; e.d = '0; e.a = 32'h0000_0010; e.be = '0; e.we = 1'b0; e.m = 1'b0;
            expq.push_back(e);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        chk1("resp_stall", stall_o, 1'b1);
        #1 rstn_i = 1'b0;
        #1;
        chk1("mrst_stall", stall_o, 1'b0);
        chk1("mrst_req", dmem_req_o, 1'b0);
        chk32("mrst_data", data_o, 32'h0);
        chk32("mrst_data_addr", data_addr_o, 32'h0);
        chk1("mrst_mem2reg", mem2reg_o, 1'b0);
        idle_ex();
        @(posedge clk_i);
        #3 rstn_i = 1'b1;
        stray_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk1("stray_no_wb", data_we_o, 1'b0);
            chk1("stray_no_stall", stall_o, 1'b0);
        end
        sync();
        cfg_rv = 0;

        // Back-to-back LW then SW.
        for (int i = 16; i < 20; i++) bmem[i] = 8'h11;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h2233_4455, 1'b0);
        @(negedge clk_i);
        chk32("b2b_data_hold", data_o, 32'h1111_1111);
        sync();

        // Randomized mix.
        for (int k = 0; k < 300; k++) begin
            cfg_gnt = $urandom_range(0, 2);
            cfg_rv  = $urandom_range(0, 2);
            op      = $urandom_range(0, 99);
            a       = 32'($urandom_range(0, 63));
            rdwe    = 1'($urandom_range(0, 1));
            if (op < 25) begin
                issue(1'b0, 1'b0, 3'($urandom_range(0, 7)), 32'($urandom), 32'h0, rdwe);
            end else begin
                if (op < 70) begin
                    f3 = 3'($urandom_range(0, 7));
                    re = 1'b1;
                end else begin
                    f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
                    re = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                    else if (f3[1:0] == 2'b01) a[0] = 1'b0;
                end
                issue(re, (op >= 70), f3, a, 32'($urandom), rdwe);
            end
            if ($urandom_range(0, 4) == 0) sync();
        end

        repeat (4) @(negedge clk_i);
        chk32("queue_empty", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
